uc_fsm_mc: RTL and testbench

Parametrised multicycle control unit for the single-memory MIPS datapath. It decodes `Op`/`Funct` from the instruction register and sequences IF → ID → EX → MA → WB. Each instruction visits only the states it needs. Memory accesses can be stretched by a fixed latency. Unsupported encodings are trapped instead of silently executing. It drives every mux select and write enable of the datapath; branch resolution (`BranchEq`/`BranchNeq` combined with ALU `Zero`) stays in the datapath.

---
 rtl/uc_fsm_mc.sv | 218 +++++++++++++++++++++
 tb/tb_uc_fsm_mc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_fsm_mc.sv
// Multicycle MIPS control unit: IF/ID/EX/MA/WB sequencer
// with stretchable memory cycles and illegal-encoding trap.
module uc_fsm_mc #(
  parameter int MEM_LAT = 0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       BranchEq,
  output logic       BranchNeq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       SignZero,
  output logic       Jal,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic [2:0] State,
  output logic       Illegal,
  output logic       IllegalSticky
);

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_LUI = 3'b111;

  typedef enum logic [2:0] {
    S_IF = 3'd0,
    S_ID = 3'd1,
    S_EX = 3'd2,
    S_MA = 3'd3,
    S_WB = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic          last;

  logic is_r, is_j, is_jal, is_beq, is_bne;
  logic is_lw, is_sw, is_andi, is_ori, is_jr;
  logic r_ok, op_ok, illegal_enc;
  logic [2:0] r_alu, i_alu;

  assign is_r    = (Op == 6'h00);
  assign is_j    = (Op == 6'h02);
  assign is_jal  = (Op == 6'h03);
  assign is_beq  = (Op == 6'h04);
  assign is_bne  = (Op == 6'h05);
  assign is_andi = (Op == 6'h0C);
  assign is_ori  = (Op == 6'h0D);
  assign is_lw   = (Op == 6'h23);
  assign is_sw   = (Op == 6'h2B);
  assign is_jr   = is_r && (Funct == 6'h08);

  assign r_ok = Funct inside {6'h08, 6'h20, 6'h21, 6'h22,
                              6'h23, 6'h24, 6'h25, 6'h27,
                              6'h2A, 6'h2B};
  assign op_ok = Op inside {6'h02, 6'h03, 6'h04, 6'h05,
                            6'h08, 6'h09, 6'h0A, 6'h0C,
                            6'h0D, 6'h0F, 6'h23, 6'h2B};
  assign illegal_enc = is_r ? !r_ok : !op_ok;

  // Final cycle of a (possibly stretched) memory state
  assign last = (MEM_LAT == 0) || (cnt_q == CW'(MEM_LAT));

  always_comb begin
    r_alu = ALU_ADD;
    case (Funct)
      6'h22, 6'h23: r_alu = ALU_SUB;
      6'h24:        r_alu = ALU_AND;
      6'h25:        r_alu = ALU_OR;
      6'h27:        r_alu = ALU_NOR;
      6'h2A:        r_alu = ALU_SLT;
      6'h2B:        r_alu = ALU_SLTU;
      default:      r_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    unique case (1'b1)
      (Op == 6'h0A): i_alu = ALU_SLT;
      is_andi:       i_alu = ALU_AND;
      is_ori:        i_alu = ALU_OR;
      (Op == 6'h0F): i_alu = ALU_LUI;
      default:       i_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IF;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    sticky_d = sticky_q | Illegal;
    if ((state_q == S_IF || state_q == S_MA) && !last)
      cnt_d = cnt_q + CW'(1);
    unique case (state_q)
      S_IF: state_d = last ? S_ID : S_IF;
      S_ID: begin
        if (illegal_enc || is_j || is_jal) state_d = S_IF;
        else                                state_d = S_EX;
      end
      S_EX: begin
        if (is_jr || is_beq || is_bne) state_d = S_IF;
        else if (is_lw || is_sw)       state_d = S_MA;
        else                           state_d = S_WB;
      end
      S_MA: begin
        if (!last)      state_d = S_MA;
        else if (is_lw) state_d = S_WB;
        else            state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    BranchEq   = 1'b0;
    BranchNeq  = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    SignZero   = 1'b0;
    Jal        = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    State      = 3'd0;
    Illegal    = 1'b0;
    // Held reset silences every control, not just the state
    if (CLR) begin
      State = state_q;
      unique case (state_q)
        S_IF: begin
          ALUSrcB = 2'b01;
          IRWrite = last;
          PCWrite = last;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          if (illegal_enc) begin
            Illegal = 1'b1;
          end else if (is_j || is_jal) begin
            PCWrite  = 1'b1;
            PCSrc    = 2'b10;
            RegWrite = is_jal;
            Jal      = is_jal;
          end
        end
        S_EX: begin
          if (is_jr) begin
            PCWrite = 1'b1;
            PCSrc   = 2'b11;
          end else if (is_r) begin
            ALUSrcA    = 1'b1;
            ALUControl = r_alu;
          end else if (is_beq || is_bne) begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            BranchEq   = is_beq;
            BranchNeq  = is_bne;
          end else begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            SignZero   = is_andi | is_ori;
            ALUControl = i_alu;
          end
        end
        S_MA: begin
          IorD     = 1'b1;
          MemWrite = is_sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = is_r;
          MemtoReg = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign IllegalSticky = sticky_q;

endmodule

// File: tb/tb_uc_fsm_mc.sv
// Scoreboard bench for uc_fsm_mc: per-cycle expected control
// words queued by stimulus, popped by per-DUT monitors.
module tb_uc_fsm_mc;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, beq, bne, iord, mw, irw;
    logic rd, m2r, rw, asa, sz, jal;
    logic [1:0] asb;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic ill, stk;
  } vec_t;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic [5:0] op0 = 6'h3F, fn0 = 6'h3F;
  logic [5:0] op2 = 6'h3F, fn2 = 6'h3F;

  logic pcw0, beq0, bne0, iord0, mw0, irw0;
  logic rd0, m2r0, rw0, asa0, sz0, jal0, ill0, stk0;
  logic [1:0] asb0, pcs0;
  logic [2:0] alu0, st0;
  logic pcw2, beq2, bne2, iord2, mw2, irw2;
  logic rd2, m2r2, rw2, asa2, sz2, jal2, ill2, stk2;
  logic [1:0] asb2, pcs2;
  logic [2:0] alu2, st2;

  vec_t act0, act2;
  vec_t q0[$], q2[$];
  bit   sticky_exp0 = 1'b0;
  bit   sticky_exp2 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  uc_fsm_mc #(.MEM_LAT(0)) u_dut0 (
    .CLK(CLK), .CLR(CLR), .Op(op0), .Funct(fn0),
    .PCWrite(pcw0), .BranchEq(beq0), .BranchNeq(bne0),
    .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0),
    .RegDst(rd0), .MemtoReg(m2r0), .RegWrite(rw0),
    .ALUSrcA(asa0), .SignZero(sz0), .Jal(jal0),
    .ALUSrcB(asb0), .ALUControl(alu0), .PCSrc(pcs0),
    .State(st0), .Illegal(ill0), .IllegalSticky(stk0)
  );

  uc_fsm_mc #(.MEM_LAT(2)) u_dut2 (
    .CLK(CLK), .CLR(CLR), .Op(op2), .Funct(fn2),
    .PCWrite(pcw2), .BranchEq(beq2), .BranchNeq(bne2),
    .IorD(iord2), .MemWrite(mw2), .IRWrite(irw2),
    .RegDst(rd2), .MemtoReg(m2r2), .RegWrite(rw2),
    .ALUSrcA(asa2), .SignZero(sz2), .Jal(jal2),
    .ALUSrcB(asb2), .ALUControl(alu2), .PCSrc(pcs2),
    .State(st2), .Illegal(ill2), .IllegalSticky(stk2)
  );

  assign act0 = {st0, pcw0, beq0, bne0, iord0, mw0, irw0,
                 rd0, m2r0, rw0, asa0, sz0, jal0,
                 asb0, alu0, pcs0, ill0, stk0};
  assign act2 = {st2, pcw2, beq2, bne2, iord2, mw2, irw2,
                 rd2, m2r2, rw2, asa2, sz2, jal2,
                 asb2, alu2, pcs2, ill2, stk2};

  always @(negedge CLK) begin
    vec_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if (act0 !== e) begin
        errors++;
        $display("FAIL mon0 t=%0t act=%h exp=%h", $time, act0, e);
      end
    end
  end

  always @(negedge CLK) begin
    vec_t e;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      checks++;
      if (act2 !== e) begin
        errors++;
        $display("FAIL mon2 t=%0t act=%h exp=%h", $time, act2, e);
      end
    end
  end

  task automatic push(input int d, input vec_t v);
    if (d == 0) begin
      v.stk = sticky_exp0;
      q0.push_back(v);
    end else begin
      v.stk = sticky_exp2;
      q2.push_back(v);
    end
  endtask

  task automatic push_if(input int d, input int L);
    vec_t v;
    for (int i = 0; i <= L; i++) begin
      v = '0;
      v.asb = 2'b01;
      v.irw = (i == L);
      v.pcw = (i == L);
      push(d, v);
    end
  endtask

  function automatic vec_t v_id();
    vec_t v;
    v = '0;
    v.st = 3'd1;
    v.asb = 2'b11;
    return v;
  endfunction

  // Op/Funct hold junk through IF and take real values from ID on
  task automatic run(input int d, input logic [5:0] op,
                     input logic [5:0] fn, input int L,
                     input int n);
    if (d == 0) begin op0 = 6'h3F; fn0 = 6'h3F; end
    else        begin op2 = 6'h3F; fn2 = 6'h3F; end
    repeat (L + 1) @(posedge CLK);
    #1;
    if (d == 0) begin op0 = op; fn0 = fn; end
    else        begin op2 = op; fn2 = fn; end
    repeat (n - L - 1) @(posedge CLK);
    #1;
  endtask

  task automatic r_type(input int d, input int L,
                        input logic [5:0] fn,
                        input logic [2:0] alu);
    vec_t v;
    push_if(d, L);
    push(d, v_id());
    v = '0; v.st = 3'd2; v.asa = 1'b1; v.alu = alu;
    push(d, v);
    v = '0; v.st = 3'd4; v.rw = 1'b1; v.rd = 1'b1;
    push(d, v);
    run(d, 6'h00, fn, L, 4 + L);
  endtask

  task automatic i_type(input int d, input int L,
                        input logic [5:0] op,
                        input logic [2:0] alu, input logic sz);
    vec_t v;
    push_if(d, L);
    push(d, v_id());
    v = '0; v.st = 3'd2; v.asa = 1'b1; v.asb = 2'b10;
    v.sz = sz; v.alu = alu;
    push(d, v);
    v = '0; v.st = 3'd4; v.rw = 1'b1;
    push(d, v);
    run(d, op, 6'h15, L, 4 + L);
  endtask

  task automatic mem(input int d, input int L, input bit lw);
    vec_t v;
    push_if(d, L);
    push(d, v_id());
    v = '0; v.st = 3'd2; v.asa = 1'b1; v.asb = 2'b10;
    push(d, v);
    for (int i = 0; i <= L; i++) begin
      v = '0; v.st = 3'd3; v.iord = 1'b1; v.mw = !lw;
      push(d, v);
    end
    if (lw) begin
      v = '0; v.st = 3'd4; v.rw = 1'b1; v.m2r = 1'b1;
      push(d, v);
    end
    run(d, lw ? 6'h23 : 6'h2B, 6'h00, L,
        lw ? 5 + 2 * L : 4 + 2 * L);
  endtask

  task automatic branch(input int d, input int L, input bit ne);
    vec_t v;
    push_if(d, L);
    push(d, v_id());
    v = '0; v.st = 3'd2; v.asa = 1'b1; v.alu = 3'b001;
    v.pcs = 2'b01; v.beq = !ne; v.bne = ne;
    push(d, v);
    run(d, ne ? 6'h05 : 6'h04, 6'h00, L, 3 + L);
  endtask

  task automatic jr(input int d, input int L);
    vec_t v;
    push_if(d, L);
    push(d, v_id());
    v = '0; v.st = 3'd2; v.pcw = 1'b1; v.pcs = 2'b11;
    push(d, v);
    run(d, 6'h00, 6'h08, L, 3 + L);
  endtask

  task automatic jump(input int d, input int L, input bit link);
    vec_t v;
    push_if(d, L);
    v = v_id(); v.pcw = 1'b1; v.pcs = 2'b10;
    v.rw = link; v.jal = link;
    push(d, v);
    run(d, link ? 6'h03 : 6'h02, 6'h00, L, 2 + L);
  endtask

  task automatic illegal(input int d, input int L,
                         input logic [5:0] op,
                         input logic [5:0] fn);
    vec_t v;
    push_if(d, L);
    v = v_id(); v.ill = 1'b1;
    push(d, v);
    run(d, op, fn, L, 2 + L);
    if (d == 0) sticky_exp0 = 1'b1;
    else        sticky_exp2 = 1'b1;
  endtask

  // ori interrupted by an asynchronous reset in EX
  task automatic abort_ori();
    push_if(0, 0);
    push(0, v_id());
    sticky_exp0 = 1'b0;
    push(0, '0);
    op0 = 6'h3F; fn0 = 6'h3F;
    @(posedge CLK); #1;
    op0 = 6'h0D; fn0 = 6'h00;
    @(posedge CLK); #1;
    CLR = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b1;
  endtask

  task automatic seq0();
    r_type(0, 0, 6'h20, 3'b000);
    mem(0, 0, 1'b0);
    branch(0, 0, 1'b0);
    branch(0, 0, 1'b1);
    r_type(0, 0, 6'h23, 3'b001);
    r_type(0, 0, 6'h27, 3'b100);
    r_type(0, 0, 6'h2B, 3'b110);
    i_type(0, 0, 6'h0D, 3'b010, 1'b1);
    i_type(0, 0, 6'h0A, 3'b101, 1'b0);
    i_type(0, 0, 6'h0F, 3'b111, 1'b0);
    jump(0, 0, 1'b0);
    jump(0, 0, 1'b1);
    jr(0, 0);
    illegal(0, 0, 6'h3F, 6'h00);
    mem(0, 0, 1'b1);
    illegal(0, 0, 6'h00, 6'h3F);
    i_type(0, 0, 6'h0C, 3'b011, 1'b1);
  endtask

  task automatic seq2();
    mem(2, 2, 1'b1);
    mem(2, 2, 1'b0);
    r_type(2, 2, 6'h2A, 3'b101);
    branch(2, 2, 1'b1);
    jump(2, 2, 1'b1);
    illegal(2, 2, 6'h11, 6'h00);
  endtask

  initial begin
    push(0, '0);
    push(2, '0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    fork
      seq0();
      seq2();
    join
    abort_ori();
    r_type(0, 0, 6'h24, 3'b011);
    mem(0, 0, 1'b0);
    @(posedge CLK); #1;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain0 left=%0d need=0", q0.size());
    end
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL drain2 left=%0d need=0", q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
